// File: rtl/i2c_byte_tx.sv
// I2C master byte transmitter: serializes WIDTH bits onto open-drain SDA, then samples the slave ACK.
// Build option: define I2C_TX_LSB_FIRST_EN to send LSB first instead of the standard MSB-first order.
module i2c_byte_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             scl_low_tick,
    input  logic             scl_high_tick,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic             ready,
    output logic             done,
    output logic             ack
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] shreg_r, shreg_s;
    logic [CW-1:0]    bitcnt_r, bitcnt_s;
    logic             sda_oe_s, ready_s, done_s, ack_s;

    // Bit currently on the wire; the bit-order option only changes these two helpers.
    function automatic logic out_bit(input logic [WIDTH-1:0] sr);
`ifdef I2C_TX_LSB_FIRST_EN
        return sr[0];
`else
        return sr[WIDTH-1];
`endif
    endfunction

    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] sr);
`ifdef I2C_TX_LSB_FIRST_EN
        return {1'b0, sr[WIDTH-1:1]};
`else
        return {sr[WIDTH-2:0], 1'b0};
`endif
    endfunction

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_s  = state_r;
        shreg_s  = shreg_r;
        bitcnt_s = bitcnt_r;
        ack_s    = ack;
        done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (load) begin
                    shreg_s  = data_in;
                    bitcnt_s = {CW{1'b0}};
                    state_s  = DATA;
                end else begin
                    state_s  = IDLE;
                end
            end
            DATA: begin
                if (scl_low_tick) begin
                    if (bitcnt_r == LAST_BIT) begin
                        state_s = ACK;
                    end else begin
                        shreg_s  = shift_out(shreg_r);
                        bitcnt_s = bitcnt_r + CNT_ONE;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            ACK: begin
                if (scl_high_tick) begin
                    ack_s   = ~sda_in;
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = ACK;
                end
            end
            default: begin
                state_s  = IDLE;
                bitcnt_s = {CW{1'b0}};
            end
        endcase

        // Outputs are computed from the next state so they register in step with it.
        if (state_s == DATA) begin
            sda_oe_s = ~out_bit(shreg_s);
        end else begin
            sda_oe_s = 1'b0;
        end
        ready_s = (state_s == IDLE);
    end

    // State and output registers; async reset releases SDA without a clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            shreg_r  <= {WIDTH{1'b0}};
            bitcnt_r <= {CW{1'b0}};
            sda_oe   <= 1'b0;
            ready    <= 1'b1;
            done     <= 1'b0;
            ack      <= 1'b0;
        end else begin
            state_r  <= state_s;
            shreg_r  <= shreg_s;
            bitcnt_r <= bitcnt_s;
            sda_oe   <= sda_oe_s;
            ready    <= ready_s;
            done     <= done_s;
            ack      <= ack_s;
        end
    end

endmodule

// File: tb/tb_i2c_byte_tx.sv
// Directed self-checking bench for i2c_byte_tx (WIDTH=8); honours I2C_TX_LSB_FIRST_EN for bit order.
module tb_i2c_byte_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       load;
    logic       scl_low_tick;
    logic       scl_high_tick;
    logic       sda_in;
    logic       sda_oe;
    logic       ready;
    logic       done;
    logic       ack;

    int checks = 0;
    int errors = 0;

    i2c_byte_tx #(.WIDTH(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .data_in       (data_in),
        .load          (load),
        .scl_low_tick  (scl_low_tick),
        .scl_high_tick (scl_high_tick),
        .sda_in        (sda_in),
        .sda_oe        (sda_oe),
        .ready         (ready),
        .done          (done),
        .ack           (ack)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Expected sda_oe for the k-th bit sent (k=0 is the first bit on the wire).
    function automatic logic exp_oe(input logic [7:0] b, input int k);
`ifdef I2C_TX_LSB_FIRST_EN
        return ~b[k];
`else
        return ~b[7-k];
`endif
    endfunction

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic inject_load);
        for (int k = 0; k < 8; k++) begin
            check_eq("bit", {15'd0, sda_oe}, {15'd0, exp_oe(b, k)});
            scl_high_tick = 1'b1;
            if (inject_load && k == 4) begin
                load    = 1'b1;
                data_in = 8'h3C;
            end
            step;
            scl_high_tick = 1'b0;
            load          = 1'b0;
            data_in       = 8'h00;
            check_eq("bit_hold", {15'd0, sda_oe}, {15'd0, exp_oe(b, k)});
            check_eq("busy", {15'd0, ready}, 16'd0);
            scl_low_tick = 1'b1;
            step;
            scl_low_tick = 1'b0;
            step;
        end
        check_eq("ack_release", {15'd0, sda_oe}, 16'd0);
        check_eq("ack_busy", {15'd0, ready}, 16'd0);
    endtask

    task automatic finish_ack(input logic sda_lvl, input logic exp_ack,
                              input logic nload, input logic [7:0] ndata);
        scl_low_tick = 1'b1;
        step;
        scl_low_tick = 1'b0;
        check_eq("ack_low_ign_oe", {15'd0, sda_oe}, 16'd0);
        check_eq("ack_low_ign_done", {15'd0, done}, 16'd0);
        sda_in        = sda_lvl;
        scl_high_tick = 1'b1;
        step;
        scl_high_tick = 1'b0;
        sda_in        = 1'b1;
        check_eq("done_pulse", {15'd0, done}, 16'd1);
        check_eq("done_ready", {15'd0, ready}, 16'd1);
        check_eq("ack_val", {15'd0, ack}, {15'd0, exp_ack});
        load    = nload;
        data_in = ndata;
        step;
        load    = 1'b0;
        data_in = 8'h00;
        check_eq("done_clear", {15'd0, done}, 16'd0);
        check_eq("ack_hold", {15'd0, ack}, {15'd0, exp_ack});
        if (nload) begin
            check_eq("b2b_ready", {15'd0, ready}, 16'd0);
            check_eq("b2b_first", {15'd0, sda_oe}, {15'd0, exp_oe(ndata, 0)});
        end else begin
            check_eq("idle_ready", {15'd0, ready}, 16'd1);
        end
    endtask

    initial begin
        reset         = 1'b1;
        data_in       = 8'h00;
        load          = 1'b0;
        scl_low_tick  = 1'b0;
        scl_high_tick = 1'b0;
        sda_in        = 1'b1;
        #12;
        check_eq("rst_oe", {15'd0, sda_oe}, 16'd0);
        check_eq("rst_ready", {15'd0, ready}, 16'd1);
        check_eq("rst_done", {15'd0, done}, 16'd0);
        check_eq("rst_ack", {15'd0, ack}, 16'd0);
        step;
        reset = 1'b0;

        // 0xFF: SDA never driven, slave NACKs
        load    = 1'b1;
        data_in = 8'hFF;
        step;
        load    = 1'b0;
        check_eq("ff_ready", {15'd0, ready}, 16'd0);
        send_byte(8'hFF, 1'b0);
        finish_ack(1'b1, 1'b0, 1'b0, 8'h00);

        // 0xA5 with a stray load mid-byte, ACKed, then 0x3C loaded in the done cycle
        load    = 1'b1;
        data_in = 8'hA5;
        step;
        load    = 1'b0;
        check_eq("a5_ready", {15'd0, ready}, 16'd0);
        send_byte(8'hA5, 1'b1);
        finish_ack(1'b0, 1'b1, 1'b1, 8'h3C);
        send_byte(8'h3C, 1'b0);
        finish_ack(1'b0, 1'b1, 1'b0, 8'h00);

        // Abort 0x00 after three low ticks
        load    = 1'b1;
        data_in = 8'h00;
        step;
        load    = 1'b0;
        for (int j = 0; j < 3; j++) begin
            scl_low_tick = 1'b1;
            step;
            scl_low_tick = 1'b0;
            step;
        end
        check_eq("abort_pre_oe", {15'd0, sda_oe}, 16'd1);
        #3;
        reset = 1'b1;
        #1;
        check_eq("abort_oe_async", {15'd0, sda_oe}, 16'd0);
        check_eq("abort_ready", {15'd0, ready}, 16'd1);
        check_eq("abort_ack", {15'd0, ack}, 16'd0);
        check_eq("abort_done", {15'd0, done}, 16'd0);
        @(posedge clock);
        #1;
        reset   = 1'b0;
        load    = 1'b1;
        data_in = 8'h5A;
        step;
        load    = 1'b0;
        check_eq("post_rst_ready", {15'd0, ready}, 16'd0);
        check_eq("post_rst_first", {15'd0, sda_oe}, {15'd0, exp_oe(8'h5A, 0)});
        check_eq("post_rst_ack", {15'd0, ack}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
